axi_mem: RTL and testbench
==========================

AXI_MEM -- requirements
Module: axi_mem

Interface
REQ-001 Parameter MEM_POWER_SIZE, default 12, log2 of memory size in bytes.
REQ-002 Parameter AXI_DATA_WIDTH, default 32, data width in bits; only 32 is supported.
REQ-003 Parameter AXI_ADDR_WIDTH, default 12, address width; SHALL equal MEM_POWER_SIZE.
REQ-004 Parameter AXI_MASK_WIDTH, default 4, SHALL equal AXI_DATA_WIDTH/8.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 CPUNC_ACLK  in  1  clock; all logic on the rising edge.
REQ-007 CPUNC_ARESET  in  1  reset, synchronous, active-high.
REQ-008 CPUNC_AWID  in  8  write ID.
REQ-009 CPUNC_AWADDR  in  AXI_ADDR_WIDTH  write byte address.
REQ-010 CPUNC_AWLN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWQOS  in  8/2/2/1/3/1/3  accepted and ignored.
REQ-011 CPUNC_AWVALID in 1, CPUNC_AWREADY out 1  write-address handshake.
REQ-012 CPUNC_WID  in  8  ignored.
REQ-013 CPUNC_WDATA  in  AXI_DATA_WIDTH  write data.
REQ-014 CPUNC_WSTRB  in  AXI_MASK_WIDTH  byte enables; bit i enables WDATA[8i+7:8i].
REQ-015 CPUNC_WLAST  in  1  ignored.
REQ-016 CPUNC_WVALID in 1, CPUNC_WREADY out 1  write-data handshake.
REQ-017 CPUNC_BID out 8, CPUNC_BRESP out 1, CPUNC_BVALID out 1, CPUNC_BREADY in 1  write response.
REQ-018 CPUNC_ARID in 8, CPUNC_ARADDR in AXI_ADDR_WIDTH, CPUNC_ARVALID in 1, CPUNC_ARREADY out 1  read address.
REQ-019 CPUNC_ARLN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS  in  8/2/2/1/3/1/3  accepted and ignored.
REQ-020 CPUNC_RID out 8, CPUNC_RDATA out AXI_DATA_WIDTH, CPUNC_RRESP out 1, CPUNC_RLAST out 1, CPUNC_RVALID out 1, CPUNC_RREADY in 1  read data.

Function
REQ-021 Storage: 2^(MEM_POWER_SIZE-2) 32-bit words, indexed by addr[MEM_POWER_SIZE-1:2]; addr[1:0] ignored; contents not reset.
REQ-022 Single-beat transfers only; one outstanding write and one outstanding read; read and write paths are independent.
REQ-023 Write path: AW and W are accepted independently in either order or the same cycle; AWREADY is 1 while no address is held, and WREADY is 1 while no data is held.
REQ-024 Write path: a handshake (VALID&READY at a rising edge) captures the address/ID or the data/strobe, and the corresponding READY drops on the next cycle.
REQ-025 Write commit: on the edge where the later of the AW and W handshakes completes, the strobed bytes are written, and BVALID=1 from the next cycle, BID=captured AWID, BRESP=0.
REQ-026 BVALID/BID are held until a BREADY handshake; on that edge BVALID drops and both holders clear, so AWREADY and WREADY return to 1 the next cycle.
REQ-027 Read path: ARREADY=1 while idle; on an AR handshake, RDATA is captured from the array (value before any same-edge write), RID=ARID, RLAST=1, RRESP=0, RVALID=1 from the next cycle, and ARREADY=0.
REQ-028 RVALID, RDATA and RID are held stable until an RREADY handshake; RVALID drops on that edge and ARREADY=1 the next cycle.
REQ-029 Maximum throughput is one read per 2 cycles and one write per 2 cycles (response accepted immediately).
REQ-030 Out-of-range address bits do not exist: AXI_ADDR_WIDTH==MEM_POWER_SIZE, so every address maps to a word and there is no wrap case.

Reset
REQ-031 While CPUNC_ARESET=1 at an edge: AWREADY=WREADY=ARREADY=0; BVALID=RVALID=RLAST=0; BID=RID=0, RDATA=0, BRESP=RRESP=0; holders clear.
REQ-032 On the first cycle after reset deasserts: AWREADY=WREADY=ARREADY=1.
REQ-033 Reset asserted mid-transaction aborts it: any pending response is dropped, and an uncommitted write is discarded.

Verification
REQ-034 AW addr 0x010 ID 0x05 and W 0xDEADBEEF strobe 0xF in the same cycle, BREADY=1 -> BVALID next cycle with BID=0x05, BRESP=0; then AR 0x010 ID 0x07 -> RDATA=0xDEADBEEF, RID=0x07, RLAST=1.
REQ-035 W 0x11223344 first, AW 0x020 three cycles later -> WREADY=0 while waiting, BVALID the cycle after AW; a read of 0x020 returns 0x11223344.
REQ-036 Word 0x030 = 0xAABBCCDD, then write 0x00000055 strobe 0x1 -> read gives 0xAABBCC55; an address of 0x033 reads the same word.
REQ-037 RREADY=0 for 5 cycles after a read -> RVALID/RDATA/RID stable and ARREADY=0 throughout; RREADY=1 -> RVALID drops and ARREADY=1 the next cycle.
REQ-038 Reset asserted while BVALID=1 -> BVALID=0 and all READYs 0 during reset, and all READYs 1 the cycle after release.

Source files
------------

// File: rtl/axi_mem.sv
// Single-beat AXI slave backed by a word-addressed RAM; independent
// write (AW/W/B) and read (AR/R) paths with one outstanding transfer each.
module axi_mem #(
   parameter int MEM_POWER_SIZE = 12,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 12,
   parameter int AXI_MASK_WIDTH = 4
) (
   input  logic                      CPUNC_ACLK,
   input  logic                      CPUNC_ARESET,
   input  logic [7:0]                CPUNC_AWID,
   input  logic [AXI_ADDR_WIDTH-1:0] CPUNC_AWADDR,
   input  logic [7:0]                CPUNC_AWLN,
   input  logic [1:0]                CPUNC_AWSIZE,
   input  logic [1:0]                CPUNC_AWBURST,
   input  logic                      CPUNC_AWLOCK,
   input  logic [2:0]                CPUNC_AWCACHE,
   input  logic                      CPUNC_AWPROT,
   input  logic [2:0]                CPUNC_AWQOS,
   input  logic                      CPUNC_AWVALID,
   output logic                      CPUNC_AWREADY,
   input  logic [7:0]                CPUNC_WID,
   input  logic [AXI_DATA_WIDTH-1:0] CPUNC_WDATA,
   input  logic [AXI_MASK_WIDTH-1:0] CPUNC_WSTRB,
   input  logic                      CPUNC_WLAST,
   input  logic                      CPUNC_WVALID,
   output logic                      CPUNC_WREADY,
   output logic [7:0]                CPUNC_BID,
   output logic                      CPUNC_BRESP,
   output logic                      CPUNC_BVALID,
   input  logic                      CPUNC_BREADY,
   input  logic [7:0]                CPUNC_ARID,
   input  logic [AXI_ADDR_WIDTH-1:0] CPUNC_ARADDR,
   input  logic [7:0]                CPUNC_ARLN,
   input  logic [1:0]                CPUNC_ARSIZE,
   input  logic [1:0]                CPUNC_ARBURST,
   input  logic                      CPUNC_ARLOCK,
   input  logic [2:0]                CPUNC_ARCACHE,
   input  logic                      CPUNC_ARPROT,
   input  logic [2:0]                CPUNC_ARQOS,
   input  logic                      CPUNC_ARVALID,
   output logic                      CPUNC_ARREADY,
   output logic [7:0]                CPUNC_RID,
   output logic [AXI_DATA_WIDTH-1:0] CPUNC_RDATA,
   output logic                      CPUNC_RRESP,
   output logic                      CPUNC_RLAST,
   output logic                      CPUNC_RVALID,
   input  logic                      CPUNC_RREADY
);
   localparam int WORDS = 2 ** (MEM_POWER_SIZE - 2);

   logic [AXI_DATA_WIDTH-1:0] mem [WORDS];

   logic                      aw_held, w_held;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
   logic [7:0]                aw_id_q;
   logic [AXI_DATA_WIDTH-1:0] w_data_q;
   logic [AXI_MASK_WIDTH-1:0] w_strb_q;

   logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
   logic [AXI_ADDR_WIDTH-1:0] wr_addr;
   logic [7:0]                wr_id;
   logic [AXI_DATA_WIDTH-1:0] wr_data;
   logic [AXI_MASK_WIDTH-1:0] wr_strb;

   // The write commits on whichever edge completes the second of AW/W,
   // taking each field from the live bus or from its holder.
   always_comb begin
      aw_hs   = CPUNC_AWVALID & CPUNC_AWREADY & ~CPUNC_ARESET;
      w_hs    = CPUNC_WVALID  & CPUNC_WREADY  & ~CPUNC_ARESET;
      b_hs    = CPUNC_BVALID  & CPUNC_BREADY  & ~CPUNC_ARESET;
      ar_hs   = CPUNC_ARVALID & CPUNC_ARREADY & ~CPUNC_ARESET;
      r_hs    = CPUNC_RVALID  & CPUNC_RREADY  & ~CPUNC_ARESET;
      commit  = (aw_hs | w_hs) & (aw_held | aw_hs) & (w_held | w_hs);
      wr_addr = aw_hs ? CPUNC_AWADDR : aw_addr_q;
      wr_id   = aw_hs ? CPUNC_AWID   : aw_id_q;
      wr_data = w_hs  ? CPUNC_WDATA  : w_data_q;
      wr_strb = w_hs  ? CPUNC_WSTRB  : w_strb_q;
   end

   always_ff @(posedge CPUNC_ACLK) begin
      if (CPUNC_ARESET) begin
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         CPUNC_AWREADY <= 1'b0;
         CPUNC_WREADY  <= 1'b0;
         CPUNC_BVALID  <= 1'b0;
         CPUNC_BID     <= '0;
      end else if (b_hs) begin
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         CPUNC_AWREADY <= 1'b1;
         CPUNC_WREADY  <= 1'b1;
         CPUNC_BVALID  <= 1'b0;
      end else begin
         if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= CPUNC_AWADDR;
            aw_id_q   <= CPUNC_AWID;
         end
         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= CPUNC_WDATA;
            w_strb_q <= CPUNC_WSTRB;
         end
         CPUNC_AWREADY <= ~(aw_held | aw_hs);
         CPUNC_WREADY  <= ~(w_held | w_hs);
         if (commit) begin
            CPUNC_BVALID <= 1'b1;
            CPUNC_BID    <= wr_id;
         end
      end
   end

   always_ff @(posedge CPUNC_ACLK) begin
      if (commit) begin
         for (int unsigned i = 0; i < AXI_MASK_WIDTH; i++) begin
            if (wr_strb[i])
               mem[wr_addr[MEM_POWER_SIZE-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge CPUNC_ACLK) begin
      if (CPUNC_ARESET) begin
         CPUNC_ARREADY <= 1'b0;
         CPUNC_RVALID  <= 1'b0;
         CPUNC_RLAST   <= 1'b0;
         CPUNC_RID     <= '0;
         CPUNC_RDATA   <= '0;
      end else if (ar_hs) begin
         CPUNC_RDATA   <= mem[CPUNC_ARADDR[MEM_POWER_SIZE-1:2]];
         CPUNC_RID     <= CPUNC_ARID;
         CPUNC_RLAST   <= 1'b1;
         CPUNC_RVALID  <= 1'b1;
         CPUNC_ARREADY <= 1'b0;
      end else if (r_hs) begin
         CPUNC_RVALID  <= 1'b0;
         CPUNC_RLAST   <= 1'b0;
         CPUNC_ARREADY <= 1'b1;
      end else if (!CPUNC_RVALID) begin
         CPUNC_ARREADY <= 1'b1;
      end
   end

   assign CPUNC_BRESP = 1'b0;
   assign CPUNC_RRESP = 1'b0;

   logic unused_inputs;
   assign unused_inputs = ^{CPUNC_AWLN, CPUNC_AWSIZE, CPUNC_AWBURST, CPUNC_AWLOCK,
                            CPUNC_AWCACHE, CPUNC_AWPROT, CPUNC_AWQOS, CPUNC_WID,
                            CPUNC_WLAST, CPUNC_ARLN, CPUNC_ARSIZE, CPUNC_ARBURST,
                            CPUNC_ARLOCK, CPUNC_ARCACHE, CPUNC_ARPROT, CPUNC_ARQOS,
                            CPUNC_AWADDR[1:0], CPUNC_ARADDR[1:0]};
endmodule

// File: tb/tb_axi_mem.sv
// Randomized bench for axi_mem: transactions checked against a word-array
// model with byte-strobe merging, plus directed handshake and reset cases.
module tb_axi_mem;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  awid, wid, arid, bid, rid;
   logic [11:0] awaddr, araddr;
   logic        awvalid, awready, wvalid, wready, wlast;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic        bresp, bvalid, bready;
   logic        arvalid, arready, rresp, rlast, rvalid, rready;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ref_mem [1024];

   always #5 clk = ~clk;

   axi_mem #(.MEM_POWER_SIZE(12), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(12), .AXI_MASK_WIDTH(4)) dut (
      .CPUNC_ACLK(clk), .CPUNC_ARESET(rst),
      .CPUNC_AWID(awid), .CPUNC_AWADDR(awaddr), .CPUNC_AWLN(8'd0), .CPUNC_AWSIZE(2'd2),
      .CPUNC_AWBURST(2'd1), .CPUNC_AWLOCK(1'b0), .CPUNC_AWCACHE(3'd0), .CPUNC_AWPROT(1'b0),
      .CPUNC_AWQOS(3'd0), .CPUNC_AWVALID(awvalid), .CPUNC_AWREADY(awready),
      .CPUNC_WID(wid), .CPUNC_WDATA(wdata), .CPUNC_WSTRB(wstrb), .CPUNC_WLAST(wlast),
      .CPUNC_WVALID(wvalid), .CPUNC_WREADY(wready),
      .CPUNC_BID(bid), .CPUNC_BRESP(bresp), .CPUNC_BVALID(bvalid), .CPUNC_BREADY(bready),
      .CPUNC_ARID(arid), .CPUNC_ARADDR(araddr), .CPUNC_ARLN(8'd0), .CPUNC_ARSIZE(2'd2),
      .CPUNC_ARBURST(2'd1), .CPUNC_ARLOCK(1'b0), .CPUNC_ARCACHE(3'd0), .CPUNC_ARPROT(1'b0),
      .CPUNC_ARQOS(3'd0), .CPUNC_ARVALID(arvalid), .CPUNC_ARREADY(arready),
      .CPUNC_RID(rid), .CPUNC_RDATA(rdata), .CPUNC_RRESP(rresp), .CPUNC_RLAST(rlast),
      .CPUNC_RVALID(rvalid), .CPUNC_RREADY(rready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic check_idle_ready(input string tag, input logic exp);
      check({tag, "_awready"}, {31'd0, awready}, {31'd0, exp});
      check({tag, "_wready"},  {31'd0, wready},  {31'd0, exp});
      check({tag, "_arready"}, {31'd0, arready}, {31'd0, exp});
   endtask

   // AW presented after aw_dly cycles, W after w_dly; B accepted after b_dly.
   task automatic do_write(input logic [11:0] a, input logic [7:0] id, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly, input int w_dly,
                           input int b_dly);
      bit   aw_done = 0, w_done = 0;
      logic aw_rdy, w_rdy;
      int   t = 0;
      while (!(aw_done && w_done) && t < 20) begin
         aw_rdy = awready;
         w_rdy  = wready;
         check("wr_awready", {31'd0, aw_rdy}, {31'd0, !aw_done});
         check("wr_wready",  {31'd0, w_rdy},  {31'd0, !w_done});
         check("wr_bvalid_early", {31'd0, bvalid}, 32'd0);
         awvalid = !aw_done && t >= aw_dly;
         awaddr  = awvalid ? a : 12'($urandom);
         awid    = awvalid ? id : 8'($urandom);
         wvalid  = !w_done && t >= w_dly;
         wdata   = wvalid ? d : $urandom;
         wstrb   = wvalid ? s : 4'($urandom);
         step();
         if (awvalid && aw_rdy) aw_done = 1;
         if (wvalid && w_rdy)   w_done  = 1;
         t++;
      end
      awvalid = 0;
      wvalid  = 0;
      if (!(aw_done && w_done)) check("wr_timeout", 32'd0, 32'd1);
      ref_mem[a[11:2]] = merge(ref_mem[a[11:2]], d, s);
      check("wr_bvalid", {31'd0, bvalid}, 32'd1);
      check("wr_bid",    {24'd0, bid},    {24'd0, id});
      check("wr_bresp",  {31'd0, bresp},  32'd0);
      repeat (b_dly) begin
         step();
         check("wr_bvalid_hold", {31'd0, bvalid}, 32'd1);
         check("wr_bid_hold",    {24'd0, bid},    {24'd0, id});
         check("wr_awready_hold", {31'd0, awready}, 32'd0);
      end
      bready = 1;
      step();
      bready = 0;
      check("wr_bvalid_drop", {31'd0, bvalid}, 32'd0);
      check("wr_awready_back", {31'd0, awready}, 32'd1);
      check("wr_wready_back",  {31'd0, wready},  32'd1);
   endtask

   task automatic do_read(input logic [11:0] a, input logic [7:0] id, input int r_dly);
      logic [31:0] exp;
      exp = ref_mem[a[11:2]];
      check("rd_arready", {31'd0, arready}, 32'd1);
      arvalid = 1;
      araddr  = a;
      arid    = id;
      step();
      arvalid = 0;
      araddr  = 12'($urandom);
      check("rd_rvalid", {31'd0, rvalid}, 32'd1);
      check("rd_rdata",  rdata, exp);
      check("rd_rid",    {24'd0, rid}, {24'd0, id});
      check("rd_rlast",  {31'd0, rlast}, 32'd1);
      check("rd_rresp",  {31'd0, rresp}, 32'd0);
      check("rd_arready_busy", {31'd0, arready}, 32'd0);
      repeat (r_dly) begin
         step();
         check("rd_rvalid_hold", {31'd0, rvalid}, 32'd1);
         check("rd_rdata_hold",  rdata, exp);
         check("rd_rid_hold",    {24'd0, rid}, {24'd0, id});
         check("rd_arready_hold", {31'd0, arready}, 32'd0);
      end
      rready = 1;
      step();
      rready = 0;
      check("rd_rvalid_drop", {31'd0, rvalid}, 32'd0);
      check("rd_arready_back", {31'd0, arready}, 32'd1);
   endtask

   initial begin
      rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
      awid = 0; awaddr = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 1; arid = 0; araddr = 0;
      step();
      step();
      check_idle_ready("rst", 1'b0);
      check("rst_bvalid", {31'd0, bvalid}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_rlast",  {31'd0, rlast},  32'd0);
      check("rst_bid",    {24'd0, bid},    32'd0);
      check("rst_rid",    {24'd0, rid},    32'd0);
      check("rst_rdata",  rdata,           32'd0);
      rst = 0;
      step();
      check_idle_ready("post_rst", 1'b1);

      for (int w = 0; w < 64; w++)
         do_write(12'(w * 4), 8'(w), $urandom, 4'hF, 0, 0, 0);

      do_write(12'h010, 8'h05, 32'hDEADBEEF, 4'hF, 0, 0, 0);
      do_read(12'h010, 8'h07, 0);
      do_write(12'h020, 8'h21, 32'h11223344, 4'hF, 3, 0, 0);
      do_read(12'h020, 8'h22, 0);
      do_write(12'h030, 8'h31, 32'hAABBCCDD, 4'hF, 0, 2, 1);
      do_write(12'h030, 8'h32, 32'h00000055, 4'h1, 0, 0, 0);
      do_read(12'h030, 8'h33, 0);
      do_read(12'h033, 8'h34, 0);
      do_read(12'h014, 8'h35, 5);

      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(1) == 0)
            do_write(12'($urandom_range(255)), 8'($urandom), $urandom, 4'($urandom),
                     int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(2)));
         else
            do_read(12'($urandom_range(255)), 8'($urandom), int'($urandom_range(2)));
      end

      // Reset while a response is pending: the committed write stays in memory.
      awvalid = 1; awaddr = 12'h040; awid = 8'h44;
      wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
      step();
      awvalid = 0; wvalid = 0;
      ref_mem[12'h040 >> 2] = 32'hCAFEF00D;
      check("rb_bvalid", {31'd0, bvalid}, 32'd1);
      rst = 1;
      step();
      check("rb_bvalid_rst", {31'd0, bvalid}, 32'd0);
      check_idle_ready("rb_rst", 1'b0);
      step();
      check_idle_ready("rb_rst2", 1'b0);
      rst = 0;
      step();
      check_idle_ready("rb_rel", 1'b1);
      check("rb_bvalid_rel", {31'd0, bvalid}, 32'd0);

      // Held W data must be discarded by reset.
      wvalid = 1; wdata = 32'h0BADBAD0; wstrb = 4'hF;
      step();
      wvalid = 0;
      check("wd_wready_held", {31'd0, wready}, 32'd0);
      rst = 1;
      step();
      check_idle_ready("wd_rst", 1'b0);
      rst = 0;
      step();
      check_idle_ready("wd_rel", 1'b1);
      awvalid = 1; awaddr = 12'h044; awid = 8'h45;
      step();
      awvalid = 0;
      repeat (2) begin
         step();
         check("wd_no_commit", {31'd0, bvalid}, 32'd0);
         check("wd_wready", {31'd0, wready}, 32'd1);
      end
      wvalid = 1; wdata = 32'h600DF00D; wstrb = 4'hF;
      step();
      wvalid = 0;
      ref_mem[12'h044 >> 2] = 32'h600DF00D;
      check("wd_bvalid", {31'd0, bvalid}, 32'd1);
      check("wd_bid", {24'd0, bid}, 32'h45);
      bready = 1;
      step();
      bready = 0;
      do_read(12'h044, 8'h46, 1);
      do_read(12'h040, 8'h47, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
